// File: rtl/c2h_resp_framer.sv
// c2h_resp_framer: turns one response descriptor plus its 256-bit payload stream
// into a single C2H AXI-Stream frame. The frame is a header beat, then ceil(len/32)
// data beats. The final beat carries an exact tkeep and tlast.
// The descriptor length alone sets the framing. The producer's pl_tlast is only checked.
module c2h_resp_framer #(
  parameter int DATA_WIDTH = 256,
  parameter int HDR_WIDTH  = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      driver_ready,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [HDR_WIDTH-1:0]      desc_hdr,
  input  logic [LEN_WIDTH-1:0]      desc_len,
  input  logic                      pl_tvalid,
  output logic                      pl_tready,
  input  logic [DATA_WIDTH-1:0]     pl_tdata,
  input  logic                      pl_tlast,
  output logic                      TX_tvalid,
  input  logic                      TX_tready,
  output logic [DATA_WIDTH-1:0]     TX_tdata,
  output logic [DATA_WIDTH/8-1:0]   TX_tkeep,
  output logic                      TX_tlast,
  output logic [31:0]               frame_cnt,
  output logic                      len_err
);
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int OFS_W  = $clog2(KEEP_W);
  localparam int PAD_W  = DATA_WIDTH - HDR_WIDTH - LEN_WIDTH - SEQ_WIDTH;

  typedef enum logic {IDLE, DATA} state_t;

  state_t                 state;
  logic [SEQ_WIDTH-1:0]   seq;
  logic [LEN_WIDTH:0]     rem_beats;
  logic [OFS_W-1:0]       last_bytes;

  logic                   ld_ok, desc_hs, pl_hs, final_beat;
  logic [LEN_WIDTH:0]     beats_calc;
  logic [KEEP_W-1:0]      last_keep, beat_keep;
  logic [DATA_WIDTH-1:0]  beat_data;

  // The output stage can take a new beat when it is empty or is draining this cycle.
  assign ld_ok      = !TX_tvalid || TX_tready;
  assign desc_ready = !sys_rst && (state == IDLE) && driver_ready && ld_ok;
  assign pl_tready  = !sys_rst && (state == DATA) && ld_ok;
  assign desc_hs    = desc_valid && desc_ready;
  assign pl_hs      = pl_tvalid && pl_tready;
  assign final_beat = (rem_beats == (LEN_WIDTH+1)'(1));

  // Use one extra bit so that a 65535-byte length rounds up to 2048 beats without overflow.
  assign beats_calc = ({1'b0, desc_len} + (LEN_WIDTH+1)'(KEEP_W-1)) >> OFS_W;
  assign last_keep  = (last_bytes == '0) ? '1 : ((KEEP_W'(1) << last_bytes) - KEEP_W'(1));
  assign beat_keep  = final_beat ? last_keep : '1;

  // Drive disabled bytes as zero so that stale payload never leaks past tkeep.
  for (genvar b = 0; b < KEEP_W; b++) begin : g_mask
    assign beat_data[8*b +: 8] = pl_tdata[8*b +: 8] & {8{beat_keep[b]}};
  end

  // FSM, output register, sequence number, frame counter and sticky length check.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      seq        <= '0;
      rem_beats  <= '0;
      last_bytes <= '0;
      TX_tvalid  <= 1'b0;
      TX_tdata   <= '0;
      TX_tkeep   <= '0;
      TX_tlast   <= 1'b0;
      frame_cnt  <= '0;
      len_err    <= 1'b0;
    end else begin
      if (TX_tvalid && TX_tready && TX_tlast)
        frame_cnt <= frame_cnt + 32'd1;
      if (ld_ok)
        TX_tvalid <= 1'b0;
      case (state)
        IDLE: if (desc_hs) begin
          TX_tvalid  <= 1'b1;
          TX_tdata   <= {{PAD_W{1'b0}}, seq, desc_len, desc_hdr};
          TX_tkeep   <= '1;
          TX_tlast   <= (desc_len == '0);
          seq        <= seq + SEQ_WIDTH'(1);
          rem_beats  <= beats_calc;
          last_bytes <= desc_len[OFS_W-1:0];
          if (desc_len != '0)
            state <= DATA;
        end
        DATA: if (pl_hs) begin
          TX_tvalid <= 1'b1;
          TX_tdata  <= beat_data;
          TX_tkeep  <= beat_keep;
          TX_tlast  <= final_beat;
          rem_beats <= rem_beats - (LEN_WIDTH+1)'(1);
          if (final_beat)
            state <= IDLE;
          if (pl_tlast != final_beat)
            len_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2h_resp_framer.sv
// tb_c2h_resp_framer: directed frame table plus hand sequences for back-to-back
// zero-length frames, driver_ready gating and reset mid-frame.
module tb_c2h_resp_framer;
  logic         clk = 1'b0;
  logic         sys_rst, driver_ready;
  logic         desc_valid, desc_ready;
  logic [63:0]  desc_hdr;
  logic [15:0]  desc_len;
  logic         pl_tvalid, pl_tready, pl_tlast;
  logic [255:0] pl_tdata;
  logic         TX_tvalid, TX_tready, TX_tlast;
  logic [255:0] TX_tdata;
  logic [31:0]  TX_tkeep;
  logic [31:0]  frame_cnt;
  logic         len_err;

  always #5 clk = ~clk;

  c2h_resp_framer dut (
    .clk(clk), .sys_rst(sys_rst), .driver_ready(driver_ready),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_hdr(desc_hdr), .desc_len(desc_len),
    .pl_tvalid(pl_tvalid), .pl_tready(pl_tready), .pl_tdata(pl_tdata), .pl_tlast(pl_tlast),
    .TX_tvalid(TX_tvalid), .TX_tready(TX_tready), .TX_tdata(TX_tdata), .TX_tkeep(TX_tkeep),
    .TX_tlast(TX_tlast), .frame_cnt(frame_cnt), .len_err(len_err)
  );

  typedef struct {
    int          len;
    logic [63:0] hdr;
    int          bad_beat;      // data beat index with flipped pl_tlast, -1 = none
    bit          stall;         // TX_tready alternates 1,0,1,0...
    int          exp_beats;     // header + data beats
    logic [31:0] exp_last_keep;
    bit          exp_len_err;   // sticky, so reflects all earlier rows too
  } vec_t;

  vec_t vecs[8];
  int   n_chk = 0, n_fail = 0;
  int   exp_seq = 0, exp_frames = 0;

  function automatic logic [255:0] pat(int k);
    logic [255:0] d;
    for (int i = 0; i < 32; i++) d[8*i +: 8] = {1'b1, 7'((k*32 + i) & 127)};
    return d;
  endfunction

  function automatic logic [255:0] expand(logic [31:0] keep);
    logic [255:0] m;
    for (int i = 0; i < 32; i++) m[8*i +: 8] = keep[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_frame(input vec_t v);
    int nb, pi, ncap;
    bit sent, done, prev_stall;
    logic [255:0] sv_d;
    logic [31:0]  sv_k, exp_k;
    logic         sv_l;
    nb = (v.len + 31) / 32; pi = 0; ncap = 0;
    sent = 0; done = 0; prev_stall = 0;
    sv_d = '0; sv_k = '0; sv_l = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      TX_tready  = v.stall ? (cyc % 2 == 0) : 1'b1;
      desc_valid = !sent;
      desc_hdr   = v.hdr;
      desc_len   = 16'(v.len);
      pl_tvalid  = sent && (pi < nb);
      pl_tdata   = pat(pi);
      pl_tlast   = ((pi == nb-1) != (pi == v.bad_beat));
      #1;
      if (prev_stall) begin
        chk("stall_vld",  256'(TX_tvalid), 256'(1'b1));
        chk("stall_data", TX_tdata, sv_d);
        chk("stall_keep", 256'(TX_tkeep), 256'(sv_k));
        chk("stall_last", 256'(TX_tlast), 256'(sv_l));
      end
      prev_stall = TX_tvalid && !TX_tready;
      sv_d = TX_tdata; sv_k = TX_tkeep; sv_l = TX_tlast;
      if (TX_tvalid && TX_tready) begin
        if (ncap == 0) begin
          chk("hdr_data", TX_tdata, {160'b0, 16'(exp_seq), 16'(v.len), v.hdr});
          chk("hdr_keep", 256'(TX_tkeep), 256'(32'hFFFF_FFFF));
        end else begin
          exp_k = (ncap == v.exp_beats-1) ? v.exp_last_keep : 32'hFFFF_FFFF;
          chk("beat_data", TX_tdata, pat(ncap-1) & expand(exp_k));
          chk("beat_keep", 256'(TX_tkeep), 256'(exp_k));
        end
        chk("beat_tlast", 256'(TX_tlast), 256'(ncap == v.exp_beats-1));
        if (TX_tlast) done = 1;
        ncap++;
      end
      if (desc_valid && desc_ready) sent = 1;
      if (pl_tvalid && pl_tready) pi++;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: len %0d got %0d beats expected %0d", v.len, ncap, v.exp_beats);
    end
    @(negedge clk);
    desc_valid = 1'b0; pl_tvalid = 1'b0; pl_tlast = 1'b0;
    #1;
    exp_frames++; exp_seq++;
    chk("beat_count", 256'(ncap), 256'(v.exp_beats));
    chk("frame_cnt", 256'(frame_cnt), 256'(exp_frames));
    chk("len_err", 256'(len_err), 256'(v.exp_len_err));
  endtask

  initial begin
    vecs[0] = '{64,    64'hA5,               -1, 0, 3,    32'hFFFF_FFFF, 0};
    vecs[1] = '{33,    64'h1111_2222_3333_4444, -1, 0, 3,  32'h0000_0001, 0};
    vecs[2] = '{0,     64'hDEAD_BEEF_0000_0001, -1, 0, 1,  32'hFFFF_FFFF, 0};
    vecs[3] = '{96,    64'h0123_4567_89AB_CDEF, -1, 1, 4,  32'hFFFF_FFFF, 0};
    vecs[4] = '{31,    64'h5A5A_5A5A_5A5A_5A5A, -1, 0, 2,  32'h7FFF_FFFF, 0};
    vecs[5] = '{32,    64'hFFFF_0000_FFFF_0000, -1, 0, 2,  32'hFFFF_FFFF, 0};
    vecs[6] = '{65535, 64'hC0DE_C0DE_C0DE_C0DE, -1, 0, 2049, 32'h7FFF_FFFF, 0};
    vecs[7] = '{96,    64'hBAD0_BAD0_BAD0_BAD0,  0, 0, 4,  32'hFFFF_FFFF, 1};

    sys_rst = 1'b1; driver_ready = 1'b1; TX_tready = 1'b1;
    desc_valid = 1'b0; desc_hdr = '0; desc_len = '0;
    pl_tvalid = 1'b0; pl_tdata = '0; pl_tlast = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tvalid", 256'(TX_tvalid), 256'(1'b0));
    chk("rst_tdata", TX_tdata, 256'(0));
    chk("rst_tkeep", 256'(TX_tkeep), 256'(0));
    chk("rst_tlast", 256'(TX_tlast), 256'(1'b0));
    chk("rst_desc_ready", 256'(desc_ready), 256'(1'b0));
    chk("rst_pl_tready", 256'(pl_tready), 256'(1'b0));
    chk("rst_frame_cnt", 256'(frame_cnt), 256'(0));
    chk("rst_len_err", 256'(len_err), 256'(1'b0));
    sys_rst = 1'b0;

    for (int i = 0; i < 8; i++) do_frame(vecs[i]);

    // Back-to-back zero-length frames: second descriptor accepted while first header drains
    @(negedge clk);
    TX_tready = 1'b1; desc_valid = 1'b1; desc_len = 16'd0; desc_hdr = 64'h1;
    #1;
    chk("z_accept1", 256'(desc_ready), 256'(1'b1));
    chk("z_pl_tready", 256'(pl_tready), 256'(1'b0));
    @(negedge clk);
    desc_hdr = 64'h2;
    #1;
    chk("z_accept2", 256'(desc_ready), 256'(1'b1));
    chk("z_hdr1", TX_tdata, {160'b0, 16'(exp_seq), 16'd0, 64'h1});
    chk("z_tlast1", 256'(TX_tvalid && TX_tlast), 256'(1'b1));
    @(negedge clk);
    desc_valid = 1'b0;
    #1;
    chk("z_hdr2", TX_tdata, {160'b0, 16'(exp_seq+1), 16'd0, 64'h2});
    chk("z_pl_tready2", 256'(pl_tready), 256'(1'b0));
    @(negedge clk);
    #1;
    exp_frames += 2; exp_seq += 2;
    chk("z_frame_cnt", 256'(frame_cnt), 256'(exp_frames));
    chk("z_idle", 256'(TX_tvalid), 256'(1'b0));

    // driver_ready low blocks acceptance
    @(negedge clk);
    driver_ready = 1'b0; desc_valid = 1'b1; desc_len = 16'd96; desc_hdr = 64'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("drv_blk_ready", 256'(desc_ready), 256'(1'b0));
      chk("drv_blk_tvalid", 256'(TX_tvalid), 256'(1'b0));
      @(negedge clk);
    end
    driver_ready = 1'b1;
    #1;
    chk("drv_accept", 256'(desc_ready), 256'(1'b1));
    @(negedge clk);
    desc_valid = 1'b0; pl_tvalid = 1'b1; pl_tdata = pat(0); pl_tlast = 1'b0;
    #1;
    chk("mid_hdr_vld", 256'(TX_tvalid), 256'(1'b1));
    // Reset mid-frame after one data beat has been loaded
    @(negedge clk);
    pl_tvalid = 1'b0; sys_rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_tvalid", 256'(TX_tvalid), 256'(1'b0));
    chk("midrst_frame_cnt", 256'(frame_cnt), 256'(0));
    chk("midrst_len_err", 256'(len_err), 256'(1'b0));
    sys_rst = 1'b0;
    @(negedge clk);
    #1;
    chk("postrst_pl_tready", 256'(pl_tready), 256'(1'b0));
    exp_seq = 0; exp_frames = 0;
    do_frame('{32, 64'hABCD, -1, 0, 2, 32'hFFFF_FFFF, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
